// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit between the pipeline and a word-addressed data memory.
// Ports: clk, reset (async, active-low);
//   request  : req_valid/req_ready, req_store, req_size, req_sext, req_addr, req_wdata, req_pc
//   response : rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   memory   : dm_we, dm_addr (word index), dm_din, dm_pc, dm_dout (combinational read)
module dm_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t      state;
  logic        store_r;
  logic [1:0]  size_r;
  logic        sext_r;
  logic [1:0]  lo_r;
  logic [31:0] wdata_r;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] merged;
  always_comb begin
    req_err   = (|req_addr[31:10]) || (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && (|req_addr[1:0]));
    lane_b    = 8'(dm_dout >> {lo_r, 3'b000});
    lane_h    = 16'(dm_dout >> {lo_r[1], 4'b0000});
    load_data = size_r == 2'b00 ? {{24{sext_r & lane_b[7]}}, lane_b} :
                size_r == 2'b01 ? {{16{sext_r & lane_h[15]}}, lane_h} : dm_dout;
    // read-modify-write: clear the addressed lane, then insert the low store bits
    merged    = size_r == 2'b00 ?
                (dm_dout & ~(32'h0000_00FF << {lo_r, 3'b000})) | ({24'b0, wdata_r[7:0]} << {lo_r, 3'b000}) :
                (dm_dout & ~(32'h0000_FFFF << {lo_r[1], 4'b0000})) | ({16'b0, wdata_r[15:0]} << {lo_r[1], 4'b0000});
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_din    <= '0;
      dm_pc     <= '0;
      store_r   <= 1'b0;
      size_r    <= '0;
      sext_r    <= 1'b0;
      lo_r      <= '0;
      wdata_r   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          store_r   <= req_store;
          size_r    <= req_size;
          sext_r    <= req_sext;
          lo_r      <= req_addr[1:0];
          wdata_r   <= req_wdata;
          dm_addr   <= req_addr[9:2];
          dm_pc     <= req_pc;
          rsp_rdata <= '0;
          req_ready <= 1'b0;
          if (req_err) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            rsp_err <= 1'b0;
            // word stores write straight through during ACCESS
            dm_we   <= req_store && req_size == 2'b10;
            dm_din  <= req_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!store_r) begin
            rsp_rdata <= load_data;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (size_r == 2'b10) begin
            dm_we     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            dm_din <= merged;
            dm_we  <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          dm_we     <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed and randomized checks of dm_lsu against a byte-level reference memory.
module tb_dm_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_pc;
  logic [31:0] dm_dout;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [7:0]  we_addr;
  logic [31:0] we_din;
  logic [31:0] last_rdata;

  dm_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_din(dm_din), .dm_pc(dm_pc), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;
  always @(posedge clk) if (dm_we) begin
    we_cnt  = we_cnt + 1;
    we_addr = dm_addr;
    we_din  = dm_din;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: size gives 1/2/4 bytes, natural alignment required, 1 KiB space.
  function automatic void model(input logic st, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd, output int lat);
    int n;
    int off;
    logic [31:0] word;
    n = 1 << sz;
    e = (a >= 32'd1024) || (sz == 2'd3) || (a % n != 0);
    rd = '0;
    lat = 1;
    if (!e) begin
      off = int'(a % 4);
      word = ref_mem[a / 4];
      if (!st) begin
        for (int j = 0; j < n; j++) rd[8*j +: 8] = word[8*(off+j) +: 8];
        if (sx && n < 4 && rd[8*n-1]) for (int k = 8*n; k < 32; k++) rd[k] = 1'b1;
        lat = 2;
      end else begin
        for (int j = 0; j < n; j++) word[8*(off+j) +: 8] = wd[8*j +: 8];
        ref_mem[a / 4] = word;
        lat = (n == 4) ? 2 : 3;
      end
    end
  endfunction

  task automatic run(input logic st, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input int bp);
    logic        e;
    logic [31:0] rd;
    logic [31:0] pc;
    int          lat;
    int          l;
    pc = $urandom;
    model(st, sz, sx, a, wd, e, rd, lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    we_cnt = 0;
    req_store = st; req_size = sz; req_sext = sx; req_addr = a; req_wdata = wd; req_pc = pc;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_store = $urandom; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!rsp_valid && l < 8);
    chk("latency", 32'(l), 32'(lat));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(e));
    chk("rsp_rdata", rsp_rdata, rd);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("dm_pc", dm_pc, pc);
    chk("dm_addr", 32'(dm_addr), 32'(a[9:2]));
    chk("we_pulses", 32'(we_cnt), (st && !e) ? 32'd1 : 32'd0);
    if (st && !e) begin
      chk("we_addr", 32'(we_addr), 32'(a[9:2]));
      chk("we_din", we_din, ref_mem[a[9:2]]);
    end
    chk("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);
    last_rdata = rsp_rdata;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, rd);
      chk("bp_err", 32'(rsp_err), 32'(e));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_dm_din", dm_din, 32'd0);
    chk("rst_dm_pc", dm_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    chk("ws_din", we_din, 32'hDEADBEEF);
    chk("ws_addr", 32'(we_addr), 32'h04);
    run(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_0055, 0);
    chk("bs_din", we_din, 32'hDE55BEEF);
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0);
    chk("lb_sext", last_rdata, 32'hFFFFFFDE);
    run(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 0);
    chk("lh_zext", last_rdata, 32'h0000BEEF);
    run(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, 0);
    run(1'b0, 2'd1, 1'b0, 32'h13, 32'd0, 0);
    run(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 0);
    run(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 0);
    run(1'b1, 2'd2, 1'b0, 32'h11, 32'h12345678, 0);
    run(1'b1, 2'd1, 1'b0, 32'h8003, 32'h12345678, 0);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5);
    old = mem[8];
    @(negedge clk);
    we_cnt = 0;
    req_store = 1'b1; req_size = 2'd0; req_sext = 1'b0; req_addr = 32'h21; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_phase_we", 32'(dm_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(dm_we), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("abort_mem", mem[8], old);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("abort_we_cnt", 32'(we_cnt), 32'd0);
    chk("abort_mem_after", mem[8], old);
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      run(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_lsu.md
DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_valid  input  1  pipeline memory request present.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-005 SHALL have port: req_store  input  1  1=store, 0=load.
REQ-006 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port: req_sext  input  1  sign-extend sub-word load data.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: req_pc  input  32  PC of the issuing instruction.
REQ-011 SHALL have port: rsp_valid  output  1  response available.
REQ-012 SHALL have port: rsp_ready  input  1  pipeline accepts response.
REQ-013 SHALL have port: rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port: rsp_err  output  1  misaligned, out-of-range or reserved-size request.
REQ-015 SHALL have port: dm_we  output  1  data-memory write enable.
REQ-016 SHALL have port: dm_addr  output  8  data-memory word index.
REQ-017 SHALL have port: dm_din  output  32  data-memory write data.
REQ-018 SHALL have port: dm_pc  output  32  PC forwarded to memory for trace.
REQ-019 SHALL have port: dm_dout  input  32  data-memory read data, combinational on dm_addr.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE; handshake is req_valid&&req_ready at the rising edge.
REQ-022 SHALL, on handshake, register store, size, sext, addr[1:0], wdata and pc; dm_addr<=req_addr[9:2]; dm_pc<=req_pc.
REQ-023 SHALL flag an error when req_addr[31:10]!=0, size==11, half with addr[0]=1, or word with addr[1:0]!=0; an erroring request goes IDLE->RESP with rsp_err=1 and rsp_rdata=0, and no dm_we pulse.
REQ-024 SHALL, for a valid load, go IDLE->ACCESS->RESP; in ACCESS capture dm_dout, extract the lane, and zero- or sign-extend into rsp_rdata.
REQ-025 SHALL use little-endian lanes: byte k = bits[8k+7:8k]; half h = bits[16h+15:16h], h=addr[1].
REQ-026 SHALL, for a word store, assert dm_we=1 for exactly the ACCESS cycle with dm_din=wdata, then go to RESP.
REQ-027 SHALL, for a byte/half store, read dm_dout in ACCESS with dm_we=0, register the merged word (only the addressed lane replaced by wdata low bits), then assert dm_we=1 in WRITE with dm_din=merged, then go to RESP.
REQ-028 SHALL hold rsp_valid=1 in RESP with stable rsp_rdata and rsp_err until rsp_ready=1, then return to IDLE.
REQ-029 SHALL allow a new handshake no earlier than the cycle after RESP exits; there is no request/response overlap.
REQ-030 SHALL keep latency from handshake edge to rsp_valid at 2 cycles for loads and word stores, 3 cycles for sub-word stores, and 1 cycle for errors.
REQ-031 SHALL ignore req_* inputs outside IDLE.
REQ-032 SHALL assert dm_we only in ACCESS (word store) or WRITE.

Reset
REQ-033 SHALL, while reset=0, force state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_we=0, dm_addr=0, dm_din=0, dm_pc=0, and clear all internal registers.
REQ-034 SHALL, on reset asserted mid-operation (ACCESS/WRITE/RESP), abort immediately with no further dm_we pulse and no response.

Verification
REQ-035 SHALL cover a word store: store addr 0x10, data 0xDEADBEEF -> one dm_we pulse, dm_addr=0x04, dm_din=0xDEADBEEF; rsp_valid 2 cycles after the handshake, rsp_err=0.
REQ-036 SHALL cover a byte store: mem[4]=0xDEADBEEF, store byte 0x55 at addr 0x12 -> dm_we in WRITE with dm_din=0xDE55BEEF, latency 3.
REQ-037 SHALL cover sign-extended loads: mem[4]=0xDE55BEEF, load byte addr 0x13 sext -> 0xFFFFFFDE; load half addr 0x10 zero-extended -> 0x0000BEEF.
REQ-038 SHALL cover errors: word at 0x11, half at 0x13, addr 0x400, size 11 -> rsp_err=1, rsp_rdata=0, no dm_we, latency 1.
REQ-039 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-040 SHALL cover reset during WRITE -> dm_we drops immediately, req_ready=1, memory unchanged, no response.
